// File: rtl/pc_fetch_if.sv
// Fetch-unit bundle: instruction-memory request, decode handoff and redirect inputs.
// Pure wiring, no latency of its own.
// Flow control is imem_req/imem_ack toward memory and instr_valid/dec_ready toward decode.
interface pc_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic        dec_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exc;

   // Fetch unit side
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
      input  imem_ack, imem_rdata, dec_ready, branch_taken, branch_target,
             jump, jump_target, exc
   );

   // Memory / decode / next-address side
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
      output imem_ack, imem_rdata, dec_ready, branch_taken, branch_target,
             jump, jump_target, exc
   );
endinterface

// File: rtl/pc_fetch.sv
// MIPS instruction-fetch front end: owns the PC, issues one word fetch at a time, holds the word for decode.
// Latency: instr_valid rises the cycle after imem_ack; zero-wait memory with ready decode gives one instr per 2 cycles.
// Backpressure: the held word stays until dec_ready (or a redirect flushes it); no new fetch is issued meanwhile.
module pc_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_fetch_if.master    bus
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_DEC} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_instr_valid;
   logic        r_redir_pend;
   logic [31:0] r_pend_tgt;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_instr_nxt;
   logic [31:0] w_instr_pc_nxt;
   logic        w_instr_valid_nxt;
   logic        w_redir_pend_nxt;
   logic [31:0] w_pend_tgt_nxt;

   logic        w_redir;
   logic [31:0] w_target;
   logic [31:0] w_pc_inc;

   // Sequential increment; the carry out of bit 31 is simply dropped so 0xFFFF_FFFC wraps to 0.
   assign w_pc_inc = r_pc + 32'd4;

   // The request is purely a function of state, so an asynchronous reset withdraws it immediately.
   assign bus.imem_req       = (r_state == FETCH);
   assign bus.imem_addr      = r_pc;
   assign bus.instr_valid    = r_instr_valid;
   assign bus.instr          = r_instr;
   assign bus.instr_pc       = r_instr_pc;
   assign bus.instr_pc_plus4 = r_instr_pc + 32'd4;

   // Redirect target select: exception beats jump beats branch; jump/branch targets are word-aligned.
   always_comb begin
      w_redir = bus.exc | bus.jump | bus.branch_taken;
      if (bus.exc)
         w_target = EXC_VECTOR;
      else if (bus.jump)
         w_target = bus.jump_target & 32'hFFFF_FFFC;
      else
         w_target = bus.branch_target & 32'hFFFF_FFFC;
   end

   // Next-state and datapath updates for the fetch FSM.
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instr_nxt       = r_instr;
      w_instr_pc_nxt    = r_instr_pc;
      w_instr_valid_nxt = r_instr_valid;
      w_redir_pend_nxt  = r_redir_pend;
      w_pend_tgt_nxt    = r_pend_tgt;
      case (r_state)
         IDLE: begin
            w_state_nxt = FETCH;
            if (w_redir)
               w_pc_nxt = w_target;
         end
         FETCH: begin
            if (bus.imem_ack) begin
               // Any ack retires a remembered redirect; a fresh redirect in this cycle wins over it.
               w_redir_pend_nxt = 1'b0;
               if (w_redir) begin
                  w_pc_nxt = w_target;
               end else if (r_redir_pend) begin
                  w_pc_nxt = r_pend_tgt;
               end else begin
                  w_instr_nxt       = bus.imem_rdata;
                  w_instr_pc_nxt    = r_pc;
                  w_instr_valid_nxt = 1'b1;
                  w_pc_nxt          = w_pc_inc;
                  w_state_nxt       = WAIT_DEC;
               end
            end else if (w_redir) begin
               // The outstanding request cannot be withdrawn, so remember where to go once it completes.
               w_redir_pend_nxt = 1'b1;
               w_pend_tgt_nxt   = w_target;
            end
         end
         WAIT_DEC: begin
            if (w_redir) begin
               w_instr_valid_nxt = 1'b0;
               w_pc_nxt          = w_target;
               w_state_nxt       = FETCH;
            end else if (bus.dec_ready) begin
               w_instr_valid_nxt = 1'b0;
               w_state_nxt       = FETCH;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= 32'h0;
         r_instr_pc    <= 32'h0;
         r_instr_valid <= 1'b0;
         r_redir_pend  <= 1'b0;
         r_pend_tgt    <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_redir_pend  <= w_redir_pend_nxt;
         r_pend_tgt    <= w_pend_tgt_nxt;
      end
   end

endmodule
